// File: rtl/sqrt_pipe.sv
// Pipelined restoring integer square root with per-stage register selection.
// Each operand carries a sideband tag that returns unchanged with its result.
module sqrt_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int FRACBITS  = 0,
  parameter int ITER      = (DATAWIDTH + FRACBITS) / 2,
  parameter logic [ITER+1:0] STAGE_MASK = '1,
  parameter int TAGWIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [DATAWIDTH-1:0] rad,
  input  logic [TAGWIDTH-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [ITER-1:0]      root,
  output logic [ITER:0]        rem,
  output logic [TAGWIDTH-1:0]  o_tag
);

  localparam int NB = 2 * ITER;
  localparam int AW = ITER + 3;
  localparam int NS = ITER + 2;

  logic [NS-1:0]       v_r;
  logic [ITER:0]       ac_r  [NS];
  logic [ITER-1:0]     q_r   [NS];
  logic [NB-1:0]       x_r   [NS];
  logic [TAGWIDTH-1:0] tag_r [NS];

  logic [NS-1:0]       v_n;
  logic [ITER:0]       ac_n  [NS];
  logic [ITER-1:0]     q_n   [NS];
  logic [NB-1:0]       x_n   [NS];
  logic [TAGWIDTH-1:0] tag_n [NS];

  logic [NS:0]         rdy_b;
  logic                out_v;
  logic [ITER:0]       out_ac;
  logic [ITER-1:0]     out_q;
  logic [TAGWIDTH-1:0] out_tag;

  // The ready seen at boundary b is high when o_ready is high or any
  // registered stage at or after b is empty (pass-through stages are transparent).
  always_comb begin
    rdy_b = '0;
    for (int b = 0; b <= NS; b++) begin
      rdy_b[b] = o_ready || (|(~v_r & STAGE_MASK & ({NS{1'b1}} << b)));
    end
  end

  // Walk the stages in order: stage 0 and ITER+1 only carry data, stages
  // 1..ITER each resolve one root bit. Invalid slots always carry zero data.
  always_comb begin : datapath
    logic [NS:0]         bv;
    logic [ITER:0]       bac  [NS+1];
    logic [ITER-1:0]     bq   [NS+1];
    logic [NB-1:0]       bx   [NS+1];
    logic [TAGWIDTH-1:0] btag [NS+1];
    logic [AW-1:0]       ac2;
    logic [AW-1:0]       test;

    bv   = '0;
    ac2  = '0;
    test = '0;
    v_n  = '0;
    for (int b = 0; b <= NS; b++) begin
      bac[b]  = '0;
      bq[b]   = '0;
      bx[b]   = '0;
      btag[b] = '0;
    end
    for (int s = 0; s < NS; s++) begin
      ac_n[s]  = '0;
      q_n[s]   = '0;
      x_n[s]   = '0;
      tag_n[s] = '0;
    end

    bv[0]   = i_valid;
    bx[0]   = i_valid ? (NB'(rad) << FRACBITS) : '0;
    btag[0] = i_valid ? i_tag : '0;

    for (int s = 0; s < NS; s++) begin
      v_n[s]   = bv[s];
      ac_n[s]  = bac[s];
      q_n[s]   = bq[s];
      x_n[s]   = bx[s];
      tag_n[s] = btag[s];

      if (s >= 1 && s <= ITER && bv[s]) begin
        ac2  = {bac[s], bx[s][NB-1 -: 2]};
        test = ac2 - AW'({bq[s], 2'b01});
        if (!test[AW-1]) begin
          ac_n[s] = test[ITER:0];
          q_n[s]  = {bq[s][ITER-2:0], 1'b1};
        end else begin
          ac_n[s] = ac2[ITER:0];
          q_n[s]  = {bq[s][ITER-2:0], 1'b0};
        end
        x_n[s] = bx[s] << 2;
      end

      if (STAGE_MASK[s]) begin
        bv[s+1]   = v_r[s];
        bac[s+1]  = ac_r[s];
        bq[s+1]   = q_r[s];
        bx[s+1]   = x_r[s];
        btag[s+1] = tag_r[s];
      end else begin
        bv[s+1]   = v_n[s];
        bac[s+1]  = ac_n[s];
        bq[s+1]   = q_n[s];
        bx[s+1]   = x_n[s];
        btag[s+1] = tag_n[s];
      end
    end

    out_v   = bv[NS];
    out_ac  = bac[NS];
    out_q   = bq[NS];
    out_tag = btag[NS];
  end

  // A registered stage loads whenever it is empty or its consumer takes the
  // current entry, so a full stage streams with no lost cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= '0;
      for (int s = 0; s < NS; s++) begin
        ac_r[s]  <= '0;
        q_r[s]   <= '0;
        x_r[s]   <= '0;
        tag_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (STAGE_MASK[s] && (!v_r[s] || rdy_b[s+1])) begin
          v_r[s]   <= v_n[s];
          ac_r[s]  <= ac_n[s];
          q_r[s]   <= q_n[s];
          x_r[s]   <= x_n[s];
          tag_r[s] <= tag_n[s];
        end
      end
    end
  end

  assign i_ready = rdy_b[0] && !rst;
  assign o_valid = out_v && !rst;
  assign root    = o_valid ? out_q   : '0;
  assign rem     = o_valid ? out_ac  : '0;
  assign o_tag   = o_valid ? out_tag : '0;

endmodule

// File: tb/tb_sqrt_pipe.sv
// Self-checking bench for sqrt_pipe: several configurations share one stimulus
// stream and are scored against a queue-based floor-sqrt reference.
module tb_sqrt_pipe;

  typedef struct packed {
    logic [31:0] rad;
    logic [3:0]  tag;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] rad_src;
  logic [3:0]  tag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  logic ir_a, ov_a, ir_f, ov_f, ir_z, ov_z, ir_16, ov_16, ir_32, ov_32;
  logic [3:0]  root_a;  logic [4:0]  rem_a;  logic [3:0] otag_a;
  logic [4:0]  root_f;  logic [5:0]  rem_f;  logic [3:0] otag_f;
  logic [3:0]  root_z;  logic [4:0]  rem_z;  logic [3:0] otag_z;
  logic [7:0]  root_16; logic [8:0]  rem_16; logic [3:0] otag_16;
  logic [15:0] root_32; logic [16:0] rem_32; logic [3:0] otag_32;

  sqrt_pipe #(.DATAWIDTH(8), .FRACBITS(0), .STAGE_MASK(6'b101101), .TAGWIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir_a), .rad(rad_src[7:0]), .i_tag(tag),
    .o_valid(ov_a), .o_ready(o_ready), .root(root_a), .rem(rem_a), .o_tag(otag_a));

  sqrt_pipe #(.DATAWIDTH(8), .FRACBITS(2), .TAGWIDTH(4)) dut_f (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir_f), .rad(rad_src[7:0]), .i_tag(tag),
    .o_valid(ov_f), .o_ready(o_ready), .root(root_f), .rem(rem_f), .o_tag(otag_f));

  sqrt_pipe #(.DATAWIDTH(8), .FRACBITS(0), .STAGE_MASK(6'b000000), .TAGWIDTH(4)) dut_z (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir_z), .rad(rad_src[7:0]), .i_tag(tag),
    .o_valid(ov_z), .o_ready(o_ready), .root(root_z), .rem(rem_z), .o_tag(otag_z));

  sqrt_pipe #(.DATAWIDTH(16), .FRACBITS(0), .STAGE_MASK(10'b1001101011), .TAGWIDTH(4)) dut_16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir_16), .rad(rad_src[15:0]), .i_tag(tag),
    .o_valid(ov_16), .o_ready(o_ready), .root(root_16), .rem(rem_16), .o_tag(otag_16));

  sqrt_pipe #(.DATAWIDTH(32), .FRACBITS(0), .TAGWIDTH(4)) dut_32 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir_32), .rad(rad_src), .i_tag(tag),
    .o_valid(ov_32), .o_ready(o_ready), .root(root_32), .rem(rem_32), .o_tag(otag_32));

  op_t q_a[$];
  op_t q_f[$];
  op_t q_z[$];
  op_t q_16[$];
  op_t q_32[$];

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned r;
    r = 64'($rtoi($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic op_t mk_op(input logic [31:0] r, input logic [3:0] t);
    op_t o;
    o.rad = r;
    o.tag = t;
    return o;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input int fb, input bit have, input op_t e,
                             input logic [63:0] a_root, input logic [63:0] a_rem, input logic [3:0] a_tag);
    longint unsigned n, r, m;
    n_checks++;
    if (!have) begin
      $display("[TB] FAIL %s result: got root=%0d rem=%0d tag=%0d, expected no result pending", name, a_root, a_rem, a_tag);
      return;
    end
    n = 64'(e.rad) << fb;
    r = isqrt(n);
    m = n - r * r;
    if (a_root === r && a_rem === m && a_tag === e.tag) n_pass++;
    else $display("[TB] FAIL %s result rad=%0d: got root=%0d rem=%0d tag=%0d, expected root=%0d rem=%0d tag=%0d",
                  name, e.rad, a_root, a_rem, a_tag, r, m, e.tag);
  endtask

  task automatic checkIdle(input string name, input logic [63:0] a_root, input logic [63:0] a_rem, input logic [3:0] a_tag);
    n_checks++;
    if (a_root === '0 && a_rem === '0 && a_tag === '0) n_pass++;
    else $display("[TB] FAIL %s idle zero: got root=%0d rem=%0d tag=%0d, expected 0 0 0", name, a_root, a_rem, a_tag);
  endtask

  // Scoreboard: record every accepted operand, score every delivered result.
  always @(negedge clk) begin : monitor
    op_t e;
    bit  have;
    if (rst) begin
      q_a.delete(); q_f.delete(); q_z.delete(); q_16.delete(); q_32.delete();
    end else begin
      if (i_valid && ir_a)  q_a.push_back(mk_op(32'(rad_src[7:0]), tag));
      if (i_valid && ir_f)  q_f.push_back(mk_op(32'(rad_src[7:0]), tag));
      if (i_valid && ir_z)  q_z.push_back(mk_op(32'(rad_src[7:0]), tag));
      if (i_valid && ir_16) q_16.push_back(mk_op(32'(rad_src[15:0]), tag));
      if (i_valid && ir_32) q_32.push_back(mk_op(rad_src, tag));

      if (ov_a && o_ready) begin
        have = q_a.size() > 0; e = have ? q_a.pop_front() : '0;
        checkOutput("dw8", 0, have, e, 64'(root_a), 64'(rem_a), otag_a);
      end else if (!ov_a) checkIdle("dw8", 64'(root_a), 64'(rem_a), otag_a);

      if (ov_f && o_ready) begin
        have = q_f.size() > 0; e = have ? q_f.pop_front() : '0;
        checkOutput("frac2", 2, have, e, 64'(root_f), 64'(rem_f), otag_f);
      end else if (!ov_f) checkIdle("frac2", 64'(root_f), 64'(rem_f), otag_f);

      if (ov_z && o_ready) begin
        have = q_z.size() > 0; e = have ? q_z.pop_front() : '0;
        checkOutput("comb", 0, have, e, 64'(root_z), 64'(rem_z), otag_z);
      end else if (!ov_z) checkIdle("comb", 64'(root_z), 64'(rem_z), otag_z);

      if (ov_16 && o_ready) begin
        have = q_16.size() > 0; e = have ? q_16.pop_front() : '0;
        checkOutput("dw16", 0, have, e, 64'(root_16), 64'(rem_16), otag_16);
      end else if (!ov_16) checkIdle("dw16", 64'(root_16), 64'(rem_16), otag_16);

      if (ov_32 && o_ready) begin
        have = q_32.size() > 0; e = have ? q_32.pop_front() : '0;
        checkOutput("dw32", 0, have, e, 64'(root_32), 64'(rem_32), otag_32);
      end else if (!ov_32) checkIdle("dw32", 64'(root_32), 64'(rem_32), otag_32);
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [3:0] t, input logic ordy);
    i_valid = v;
    rad_src = r;
    tag     = t;
    o_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 4'd0, 1'b1);
  endtask

  int exp_root[4] = '{15, 12, 0, 1};
  int exp_rem[4]  = '{30, 0, 0, 1};
  int lit_rad[4]  = '{255, 144, 0, 2};

  initial begin
    rst = 1'b1; i_valid = 1'b1; rad_src = 32'd99; tag = 4'd5; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst o_valid", 64'(ov_a), 0);
    checkVal("rst root", 64'(root_a), 0);
    checkVal("rst rem", 64'(rem_a), 0);
    checkVal("rst o_tag", 64'(otag_a), 0);
    checkVal("rst comb o_valid", 64'(ov_z), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    checkVal("post-rst o_valid", 64'(ov_a), 0);
    checkVal("post-rst i_ready", 64'(ir_a), 1);
    checkVal("post-rst frac i_ready", 64'(ir_f), 1);
    @(posedge clk);
    #1;

    // Back-to-back operands through the 4-register configuration.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'(lit_rad[k]), 4'(k + 1), 1'b1);
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkVal($sformatf("seq%0d o_valid", k), 64'(ov_a), 1);
      checkVal($sformatf("seq%0d root", k), 64'(root_a), 64'(exp_root[k]));
      checkVal($sformatf("seq%0d rem", k), 64'(rem_a), 64'(exp_rem[k]));
      @(posedge clk);
      #1;
    end
    idle(12);

    // Backpressure: stall the output until every register is occupied.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 32'((k + 4) * (k + 4)), 4'(k + 1), 1'b0);
    @(negedge clk);
    checkVal("stall i_ready", 64'(ir_a), 0);
    checkVal("stall o_valid", 64'(ov_a), 1);
    checkVal("stall root", 64'(root_a), 4);
    checkVal("stall tag", 64'(otag_a), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkVal($sformatf("drain%0d o_valid", k), 64'(ov_a), 1);
      checkVal($sformatf("drain%0d root", k), 64'(root_a), 64'(k + 4));
      checkVal($sformatf("drain%0d tag", k), 64'(otag_a), 64'(k + 1));
      @(posedge clk);
      #1;
    end
    idle(12);

    // Fractional configuration, seven registered stages.
    applyStimulus(1'b1, 32'd2, 4'd3, 1'b1);
    applyStimulus(1'b1, 32'd255, 4'd4, 1'b1);
    idle(5);
    @(negedge clk);
    checkVal("frac rad2 o_valid", 64'(ov_f), 1);
    checkVal("frac rad2 root", 64'(root_f), 2);
    checkVal("frac rad2 rem", 64'(rem_f), 4);
    checkVal("frac rad2 tag", 64'(otag_f), 3);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("frac rad255 root", 64'(root_f), 31);
    checkVal("frac rad255 rem", 64'(rem_f), 59);
    idle(10);

    // Fully combinational configuration.
    i_valid = 1'b1; rad_src = 32'd200; tag = 4'd7; o_ready = 1'b1;
    @(negedge clk);
    checkVal("comb o_valid", 64'(ov_z), 1);
    checkVal("comb root", 64'(root_z), 14);
    checkVal("comb rem", 64'(rem_z), 4);
    checkVal("comb i_ready high", 64'(ir_z), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    checkVal("comb i_ready low", 64'(ir_z), 0);
    @(posedge clk);
    #1;
    idle(12);

    // Reset with operands in flight, then a fresh operand.
    applyStimulus(1'b1, 32'd10, 4'd1, 1'b1);
    applyStimulus(1'b1, 32'd20, 4'd2, 1'b1);
    applyStimulus(1'b1, 32'd30, 4'd3, 1'b1);
    rst = 1'b1; i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; i_valid = 1'b1; rad_src = 32'd81; tag = 4'd9;
    @(negedge clk);
    checkVal("flush o_valid", 64'(ov_a), 0);
    checkVal("flush i_ready", 64'(ir_a), 1);
    @(posedge clk);
    #1;
    idle(3);
    @(negedge clk);
    checkVal("after-flush o_valid", 64'(ov_a), 1);
    checkVal("after-flush root", 64'(root_a), 9);
    checkVal("after-flush rem", 64'(rem_a), 0);
    checkVal("after-flush tag", 64'(otag_a), 9);
    @(posedge clk);
    #1;
    idle(12);

    // Randomised traffic with occasional extreme radicands.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [31:0] r;
      sel = $urandom_range(0, 7);
      r = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, r, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    idle(40);
    checkVal("dw8 leftover", 64'(q_a.size()), 0);
    checkVal("frac2 leftover", 64'(q_f.size()), 0);
    checkVal("comb leftover", 64'(q_z.size()), 0);
    checkVal("dw16 leftover", 64'(q_16.size()), 0);
    checkVal("dw32 leftover", 64'(q_32.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
